// File: rtl/dll_rx_fc_credit_alloc.sv
// Receive-side flow-control credit allocator: tracks freed header/data buffers and
// publishes CREDITS_ALLOCATED snapshots to the UpdateFC sender via a req/ack handshake.
module dll_rx_fc_credit_alloc #(
  parameter logic [11:0] HDR_INIT      = 12'd32,
  parameter logic [11:0] DATA_INIT     = 12'd256,
  parameter int unsigned HDR_THRESH    = 4,
  parameter int unsigned DATA_THRESH   = 32,
  parameter logic [15:0] UPDATE_PERIOD = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dlc_state_i,
  input  logic        hdr_release_i,
  input  logic        data_release_valid_i,
  input  logic [7:0]  data_release_cnt_i,
  input  logic        updatefc_ack_i,
  output logic        updatefc_req_o,
  output logic [11:0] hdr_credit_o,
  output logic [11:0] data_credit_o
);

  localparam logic [1:0]  DlInactive = 2'b00;
  localparam logic [1:0]  DlActive   = 2'b11;
  localparam logic [11:0] HdrThr     = 12'(HDR_THRESH);
  localparam logic [11:0] DataThr    = 12'(DATA_THRESH);

  typedef enum logic {StIdle, StReq} state_e;

  state_e      r_state, w_state_nxt;
  logic [11:0] r_hdr_live, r_data_live, r_hdr_snap, r_data_snap;
  logic [15:0] r_timer;
  logic        r_prev_active;

  logic        w_active, w_inactive, w_trigger, w_snap_en, w_ack_taken;
  logic [11:0] w_hdr_pend, w_data_pend;
  logic [15:0] w_timer_inc;

  assign w_active    = (dlc_state_i == DlActive);
  assign w_inactive  = (dlc_state_i == DlInactive);
  assign w_hdr_pend  = r_hdr_live - r_hdr_snap;
  assign w_data_pend = r_data_live - r_data_snap;
  assign w_timer_inc = (r_timer >= UPDATE_PERIOD) ? UPDATE_PERIOD : r_timer + 16'd1;
  assign w_ack_taken = (r_state == StReq) && updatefc_ack_i;

  // Timer expiry covers both the pending-credit refresh and the keep-alive refresh.
  assign w_trigger = !r_prev_active || (w_hdr_pend >= HdrThr) || (w_data_pend >= DataThr) ||
                     (r_timer == UPDATE_PERIOD);

  always_comb begin
    w_state_nxt = r_state;
    w_snap_en   = 1'b0;
    if (!w_active) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_trigger) begin
            w_state_nxt = StReq;
            w_snap_en   = 1'b1;
          end
        end
        StReq: begin
          if (updatefc_ack_i) w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_inactive) begin
      r_hdr_live    <= HDR_INIT;
      r_hdr_snap    <= HDR_INIT;
      r_data_live   <= DATA_INIT;
      r_data_snap   <= DATA_INIT;
      r_timer       <= 16'd0;
      r_prev_active <= 1'b0;
    end else if (!w_active) begin
      r_timer       <= 16'd0;
      r_prev_active <= 1'b0;
    end else begin
      r_prev_active <= 1'b1;
      if (hdr_release_i)        r_hdr_live  <= r_hdr_live + 12'd1;
      if (data_release_valid_i) r_data_live <= r_data_live + {4'd0, data_release_cnt_i};
      // Snapshot takes the pre-release live values; same-cycle releases go to the next update.
      if (w_snap_en) begin
        r_hdr_snap  <= r_hdr_live;
        r_data_snap <= r_data_live;
      end
      r_timer <= w_ack_taken ? 16'd0 : w_timer_inc;
    end
  end

  assign updatefc_req_o = (r_state == StReq);
  assign hdr_credit_o   = r_hdr_snap;
  assign data_credit_o  = r_data_snap;

endmodule

// File: tb/tb_dll_rx_fc_credit_alloc.sv
// Randomized and directed bench for dll_rx_fc_credit_alloc against a behavioural credit model.
module tb_dll_rx_fc_credit_alloc;

  localparam int HdrInit  = 32;
  localparam int DataInit = 256;
  localparam int HdrThr   = 4;
  localparam int DataThr  = 32;
  localparam int Period   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  st = 2'b00;
  logic        hrel = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  dcnt = 8'd0;
  logic        ack = 1'b0;
  logic        o_req;
  logic [11:0] o_hdr, o_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integers, credits modulo 4096.
  int m_hl = HdrInit, m_hs = HdrInit, m_dl = DataInit, m_ds = DataInit, m_timer = 0;
  bit m_req = 1'b0, m_prev = 1'b0;

  always #5 clk = ~clk;

  dll_rx_fc_credit_alloc #(
    .HDR_INIT     (12'd32),
    .DATA_INIT    (12'd256),
    .HDR_THRESH   (4),
    .DATA_THRESH  (32),
    .UPDATE_PERIOD(16'd8)
  ) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dlc_state_i         (st),
    .hdr_release_i       (hrel),
    .data_release_valid_i(dv),
    .data_release_cnt_i  (dcnt),
    .updatefc_ack_i      (ack),
    .updatefc_req_o      (o_req),
    .hdr_credit_o        (o_hdr),
    .data_credit_o       (o_data)
  );

  task automatic model_update();
    int  hp, dp;
    bit  trig;
    if (!rst_n || st == 2'b00) begin
      m_hl = HdrInit; m_hs = HdrInit; m_dl = DataInit; m_ds = DataInit;
      m_req = 1'b0; m_timer = 0; m_prev = 1'b0;
    end else if (st != 2'b11) begin
      m_req = 1'b0; m_timer = 0; m_prev = 1'b0;
    end else begin
      hp   = (m_hl - m_hs + 4096) % 4096;
      dp   = (m_dl - m_ds + 4096) % 4096;
      trig = !m_prev || hp >= HdrThr || dp >= DataThr || m_timer == Period;
      if (m_req && ack) begin
        m_req = 1'b0; m_timer = 0;
      end else begin
        if (!m_req && trig) begin
          m_req = 1'b1; m_hs = m_hl; m_ds = m_dl;
        end
        m_timer = (m_timer < Period) ? m_timer + 1 : Period;
      end
      if (hrel) m_hl = (m_hl + 1) % 4096;
      if (dv)   m_dl = (m_dl + int'(dcnt)) % 4096;
      m_prev = 1'b1;
    end
  endtask

  // Advance one clock; model follows the inputs that were stable at the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Stop releases and complete two handshakes so that no credits remain pending.
  task automatic drain();
    hrel = 1'b0; dv = 1'b0; ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40 && o_req !== 1'b1; i++) step();
      n_vec++;
      if (o_req !== 1'b1) begin
        n_err++;
        $display("FAIL drain_wait: req=%b required 1 within 40 cycles", o_req);
      end
      ack = 1'b1; step(); ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st = 2'b11; hrel = 1'b1; dv = 1'b1; dcnt = 8'd9; ack = 1'b1;
    step();
    n_vec++;
    if (o_req !== 1'b0 || o_hdr !== 12'd32 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL reset: req=%b hdr=%0d data=%0d required 0/32/256", o_req, o_hdr, o_data);
    end
    rst_n = 1'b1; st = 2'b00; hrel = 1'b0; dv = 1'b0; ack = 1'b0;
    step();
    n_vec++;
    if (o_req !== 1'b0 || o_hdr !== 12'd32 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL inactive: req=%b hdr=%0d data=%0d required 0/32/256", o_req, o_hdr, o_data);
    end
  endtask

  task automatic test_link_up();
    st = 2'b11;
    step();
    n_vec++;
    if (o_req !== 1'b1 || o_hdr !== 12'd32 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL link_up: req=%b hdr=%0d data=%0d required 1/32/256", o_req, o_hdr, o_data);
    end
    ack = 1'b1; step(); ack = 1'b0;
    n_vec++;
    if (o_req !== 1'b0) begin
      n_err++;
      $display("FAIL link_up_ack: req=%b required 0", o_req);
    end
  endtask

  task automatic test_hdr_thresh();
    hrel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (o_req !== 1'b0) begin
        n_err++;
        $display("FAIL hdr_early_%0d: req=%b required 0", i, o_req);
      end
    end
    hrel = 1'b0;
    step();
    n_vec++;
    if (o_req !== 1'b1 || o_hdr !== 12'd36 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL hdr_thresh: req=%b hdr=%0d data=%0d required 1/36/256", o_req, o_hdr, o_data);
    end
    hrel = 1'b1; dv = 1'b1; dcnt = 8'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (o_req !== 1'b1 || o_hdr !== 12'd36 || o_data !== 12'd256) begin
        n_err++;
        $display("FAIL hdr_frozen_%0d: req=%b hdr=%0d data=%0d required 1/36/256",
                 i, o_req, o_hdr, o_data);
      end
    end
    hrel = 1'b0; dv = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_timer_refresh();
    logic [11:0] h0, d0;
    drain();
    h0 = 12'(m_hs); d0 = 12'(m_ds);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 9; i++) begin
        step();
        n_vec++;
        if (i < 9 && o_req !== 1'b0) begin
          n_err++;
          $display("FAIL refresh_early_%0d_%0d: req=%b required 0", r, i, o_req);
        end else if (i == 9 && (o_req !== 1'b1 || o_hdr !== h0 || o_data !== d0)) begin
          n_err++;
          $display("FAIL refresh_%0d: req=%b hdr=%0d data=%0d required 1/%0d/%0d",
                   r, o_req, o_hdr, o_data, h0, d0);
        end
      end
      ack = 1'b1; step(); ack = 1'b0;
    end
  endtask

  task automatic test_wrap();
    int rem;
    logic [11:0] h0;
    drain();
    rem = ((4090 - m_dl) % 4096 + 4096) % 4096;
    while (rem > 0) begin
      dcnt = (rem > 255) ? 8'd255 : 8'(rem);
      dv = 1'b1; ack = m_req;
      step();
      rem -= int'(dcnt);
    end
    dv = 1'b0; ack = 1'b0;
    drain();
    n_vec++;
    if (o_data !== 12'd4090) begin
      n_err++;
      $display("FAIL wrap_base: data=%0d required 4090", o_data);
    end
    h0 = 12'(m_hs);
    dv = 1'b1; dcnt = 8'd10;
    for (int i = 1; i <= 9; i++) begin
      step();
      dv = 1'b0;
      n_vec++;
      if (i < 9 && o_req !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_pend_%0d: req=%b required 0", i, o_req);
      end else if (i == 9 && (o_req !== 1'b1 || o_data !== 12'd4 || o_hdr !== h0)) begin
        n_err++;
        $display("FAIL wrap: req=%b hdr=%0d data=%0d required 1/%0d/4", o_req, o_hdr, o_data, h0);
      end
    end
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [11:0] h0, d0;
    drain();
    h0 = 12'(m_hs); d0 = 12'(m_ds);
    hrel = 1'b1;
    for (int i = 0; i < 4; i++) step();
    dv = 1'b1; dcnt = 8'd5;
    step();
    hrel = 1'b0; dv = 1'b0;
    n_vec++;
    if (o_req !== 1'b1 || o_hdr !== h0 + 12'd4 || o_data !== d0) begin
      n_err++;
      $display("FAIL same_cycle_snap: req=%b hdr=%0d data=%0d required 1/%0d/%0d",
               o_req, o_hdr, o_data, h0 + 12'd4, d0);
    end
    ack = 1'b1; step(); ack = 1'b0;
    for (int i = 0; i < 20 && o_req !== 1'b1; i++) step();
    n_vec++;
    if (o_req !== 1'b1 || o_hdr !== h0 + 12'd5 || o_data !== d0 + 12'd5) begin
      n_err++;
      $display("FAIL same_cycle_next: req=%b hdr=%0d data=%0d required 1/%0d/%0d",
               o_req, o_hdr, o_data, h0 + 12'd5, d0 + 12'd5);
    end
  endtask

  // Entered with a request outstanding and not acknowledged.
  task automatic test_link_drop();
    hrel = 1'b1; dv = 1'b1; dcnt = 8'd3;
    step(); step();
    st = 2'b00;
    step();
    n_vec++;
    if (o_req !== 1'b0 || o_hdr !== 12'd32 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL link_drop: req=%b hdr=%0d data=%0d required 0/32/256", o_req, o_hdr, o_data);
    end
    hrel = 1'b0; dv = 1'b0;
    step();
    st = 2'b11;
    step();
    n_vec++;
    if (o_req !== 1'b1 || o_hdr !== 12'd32 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL relink: req=%b hdr=%0d data=%0d required 1/32/256", o_req, o_hdr, o_data);
    end
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    hrel = 1'b1;
    for (int i = 0; i < 20 && o_req !== 1'b1; i++) step();
    rst_n = 1'b0; dv = 1'b1; dcnt = 8'd40;
    step();
    n_vec++;
    if (o_req !== 1'b0 || o_hdr !== 12'd32 || o_data !== 12'd256) begin
      n_err++;
      $display("FAIL reset_mid_req: req=%b hdr=%0d data=%0d required 0/32/256",
               o_req, o_hdr, o_data);
    end
    rst_n = 1'b1; hrel = 1'b0; dv = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      st    = ($urandom_range(0, 19) < 17) ? 2'b11 : 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 99) != 0);
      hrel  = ($urandom_range(0, 3) == 0);
      dv    = ($urandom_range(0, 3) == 0);
      dcnt  = 8'($urandom_range(0, 255));
      ack   = ($urandom_range(0, 2) == 0);
      step();
      n_vec++;
      if ({o_req, o_hdr, o_data} !== {m_req, 12'(m_hs), 12'(m_ds)}) begin
        n_err++;
        $display("FAIL random_%0d: req=%b hdr=%0d data=%0d required %b/%0d/%0d",
                 i, o_req, o_hdr, o_data, m_req, m_hs, m_ds);
      end
    end
    rst_n = 1'b1; hrel = 1'b0; dv = 1'b0; ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_link_up();
    test_hdr_thresh();
    test_timer_refresh();
    test_wrap();
    test_same_cycle();
    test_link_drop();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dll_rx_fc_credit_alloc.md
DLL_RX_FC_CREDIT_ALLOC -- requirements
Module: dll_rx_fc_credit_alloc

Interface
REQ-001 Parameter HDR_INIT, default 12'd32, header credits advertised at link-up.
REQ-002 Parameter DATA_INIT, default 12'd256, data credits (16-byte units) advertised at link-up.
REQ-003 Parameter HDR_THRESH, default 4, count of unadvertised header credits that forces an update.
REQ-004 Parameter DATA_THRESH, default 32, count of unadvertised data credits that forces an update.
REQ-005 Parameter UPDATE_PERIOD, default 16'd1024, refresh interval in cycles.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 dlc_state_i  in  2  DLCMSM state: 00 DL_INACTIVE, 01 DL_FEATURE, 10 DL_INIT, 11 DL_ACTIVE.
REQ-009 hdr_release_i  in  1  one header buffer freed by the transaction layer this cycle.
REQ-010 data_release_valid_i  in  1  qualifies data_release_cnt_i.
REQ-011 data_release_cnt_i  in  8  data credits freed this cycle.
REQ-012 updatefc_ack_i  in  1  UpdateFC sender has consumed the current snapshot.
REQ-013 updatefc_req_o  out  1  snapshot valid, UpdateFC requested; held until acknowledged.
REQ-014 hdr_credit_o  out  12  header CREDITS_ALLOCATED snapshot, held stable while updatefc_req_o=1.
REQ-015 data_credit_o  out  12  data CREDITS_ALLOCATED snapshot, held stable while updatefc_req_o=1.

Function
REQ-016 The block SHALL keep live counters hdr_live and data_live, both 12-bit and wrapping modulo 4096.
REQ-017 The block SHALL keep snapshot registers hdr_snap and data_snap that drive hdr_credit_o and data_credit_o directly.
REQ-018 In DL_ACTIVE, a high hdr_release_i SHALL increment hdr_live by 1 on the next edge.
REQ-019 In DL_ACTIVE, a high data_release_valid_i SHALL add data_release_cnt_i (zero-extended) to data_live; simultaneous header and data releases SHALL both apply.
REQ-020 Outside DL_ACTIVE, release inputs SHALL be ignored.
REQ-021 In DL_INACTIVE, live counters and snapshots SHALL load HDR_INIT/DATA_INIT, the timer SHALL clear, and the FSM SHALL go to IDLE.
REQ-022 In DL_FEATURE and DL_INIT, all counters and snapshots SHALL hold.
REQ-023 Pending deltas SHALL be hdr_pend=(hdr_live-hdr_snap) mod 4096 and data_pend=(data_live-data_snap) mod 4096.
REQ-024 The refresh timer SHALL be 16-bit, increment each DL_ACTIVE cycle, saturate at UPDATE_PERIOD, and clear on accepted ack or outside DL_ACTIVE.
REQ-025 The FSM SHALL have two states: IDLE (req=0) and REQ (req=1).
REQ-026 IDLE->REQ SHALL occur, in DL_ACTIVE, on any of the following triggers:
- first DL_ACTIVE cycle after a non-ACTIVE cycle;
- hdr_pend>=HDR_THRESH;
- data_pend>=DATA_THRESH;
- (hdr_pend!=0 or data_pend!=0) and timer==UPDATE_PERIOD;
- timer==UPDATE_PERIOD with no pending credits (keep-alive refresh).
REQ-027 On the IDLE->REQ edge, snapshots SHALL capture the pre-increment hdr_live/data_live register values; a release in that same cycle lands in the live counters and appears in the next snapshot.
REQ-028 updatefc_req_o SHALL assert the cycle after the trigger (1-cycle latency) and remain high, with outputs frozen, until updatefc_ack_i=1 while in REQ.
REQ-029 REQ->IDLE SHALL occur on updatefc_ack_i=1; ack while IDLE SHALL be ignored.
REQ-030 After an ack, a trigger still true SHALL re-enter REQ no earlier than one IDLE cycle later (minimum 1 idle cycle between requests).
REQ-031 Leaving DL_ACTIVE while in REQ SHALL deassert updatefc_req_o on the next edge without an ack; snapshots SHALL hold unless the new state is DL_INACTIVE (REQ-021).

Reset
REQ-032 With rst_n=0 at a rising edge, the block SHALL set:
- updatefc_req_o=0;
- FSM=IDLE;
- timer=0;
- hdr_live=hdr_snap=HDR_INIT;
- data_live=data_snap=DATA_INIT;
- the internal previous-state flag to non-ACTIVE.
REQ-033 Reset SHALL override every input, including reset asserted mid-REQ.

Verification
REQ-034 Reset, then dlc_state_i=11 -> req=1 one cycle later with hdr_credit_o=32 and data_credit_o=256; ack -> req=0 next cycle.
REQ-035 In ACTIVE/IDLE, four hdr_release_i pulses -> req rises 1 cycle after hdr_pend reaches 4, hdr_credit_o=36; releases during REQ leave outputs unchanged.
REQ-036 data_live=4090, release 10 -> data_live=4, wrapping modulo 4096; data_pend computes to 10 across the wrap.
REQ-037 No releases, UPDATE_PERIOD=8 -> refresh req after 8 ACTIVE cycles with unchanged snapshot; ack clears the timer.
REQ-038 In REQ with no ack, dlc_state_i->00 -> req=0 next cycle, outputs reload 32/256; returning to 11 triggers a new initial request.
REQ-039 Header and data releases in the same cycle as the IDLE->REQ trigger -> snapshot excludes them; after ack, the next request includes them.
